// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared types, codes and legality check for the data-bus Wishbone bridge
package dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        SLV_RAM = 1'b0,
        SLV_RSA = 1'b1
    } slave_t;

    localparam logic [3:0] RSA_REGION_DEF = 4'h4;
    localparam int         TIMEOUT_DEF    = 16;

    // Natural alignment only; size code 3 is never legal.
    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b1;
            SZ_H:    return ~off[0];
            SZ_W:    return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dbus_wb_bridge_if.sv
// rtl/dbus_wb_bridge_if.sv - core data-port and Wishbone-side interfaces of the bridge
//   dbus_core_if : core_req/we/size/addr/wdata toward the bridge, stall/done/err/rdata back
//                  master = core, slave = bridge
//   dbus_wb_if   : shared adr/dat/sel/we/cyc, per-slave stb/ack/dat (RAM and RSA)
//                  master = bridge, slave = the two Wishbone slaves
interface dbus_core_if;
    logic        core_req;
    logic        core_we;
    logic [1:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic        core_done;
    logic        core_err;
    logic [31:0] core_rdata;

    modport master (
        output core_req, core_we, core_size, core_addr, core_wdata,
        input  core_stall, core_done, core_err, core_rdata
    );
    modport slave (
        input  core_req, core_we, core_size, core_addr, core_wdata,
        output core_stall, core_done, core_err, core_rdata
    );
endinterface

interface dbus_wb_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        ram_stb_o;
    logic        rsa_stb_o;
    logic        ram_ack_i;
    logic        rsa_ack_i;
    logic [31:0] ram_dat_i;
    logic [31:0] rsa_dat_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, ram_stb_o, rsa_stb_o,
        input  ram_ack_i, rsa_ack_i, ram_dat_i, rsa_dat_i
    );
    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, ram_stb_o, rsa_stb_o,
        output ram_ack_i, rsa_ack_i, ram_dat_i, rsa_dat_i
    );
endinterface

// File: rtl/dbus_wb_bridge_lane_align.sv
// rtl/dbus_wb_bridge_lane_align.sv - combinational byte-lane steering for the data bus
//   size, off     : access size code and addr[1:0] of the incoming request
//   wdata         : lane-0 aligned store data -> wdata_sh shifted to the target lanes, sel = byte enables
//   rd_off, rdata : offset of the in-flight access and raw slave data -> rdata_sh shifted to lane 0
module dbus_lane_align
    import dbus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_sh,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_sh
);

    always_comb begin
        sel = 4'b0000;
        case (size)
            SZ_B:    sel = 4'b0001 << off;
            SZ_H:    sel = 4'b0011 << off;
            SZ_W:    sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
    end

    assign wdata_sh = wdata << {off, 3'b000};
    assign rdata_sh = rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/dbus_wb_bridge.sv
// rtl/dbus_wb_bridge.sv - one Wishbone classic cycle per core load/store, RAM/RSA decode, stall until ack
//   clk, rst : clock, synchronous active-high reset (aborts any cycle, no done pulse)
//   core     : dbus_core_if.slave  - request from the core, stall/done/err/rdata back
//   wb       : dbus_wb_if.master   - shared Wishbone signals plus RAM and RSA strobes/acks/data
//   Optional macro DBUS_TIMEOUT_EN: abort with error after TIMEOUT bus cycles without ack.
module dbus_wb_bridge
    import dbus_pkg::*;
#(
    parameter logic [3:0] RSA_REGION = RSA_REGION_DEF
`ifdef DBUS_TIMEOUT_EN
    , parameter int       TIMEOUT    = TIMEOUT_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst,
    dbus_core_if.slave  core,
    dbus_wb_if.master   wb
);

    state_t      state_q, state_d;
    logic        accept, fail, capture, tmo_hit;

    logic [31:0] adr_q, dat_q, rdata_q;
    logic [3:0]  sel_q;
    logic [1:0]  off_q;
    logic        we_q, err_q;
    slave_t      slv_q;

    logic [3:0]  sel_c;
    logic [31:0] wdata_c, rdata_c;
    logic        ack_c;
    logic [31:0] dat_c;

    dbus_lane_align u_align (
        .size     (core.core_size),
        .off      (core.core_addr[1:0]),
        .wdata    (core.core_wdata),
        .sel      (sel_c),
        .wdata_sh (wdata_c),
        .rd_off   (off_q),
        .rdata    (dat_c),
        .rdata_sh (rdata_c)
    );

    // Only the addressed slave may end the cycle; the other one's ack is noise.
    assign ack_c = (slv_q == SLV_RSA) ? wb.rsa_ack_i : wb.ram_ack_i;
    assign dat_c = (slv_q == SLV_RSA) ? wb.rsa_dat_i : wb.ram_dat_i;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        fail    = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core.core_req && !core.core_done) begin
                    if (access_legal(core.core_size, core.core_addr[1:0])) begin
                        accept  = 1'b1;
                        state_d = ST_BUS;
                    end else begin
                        fail    = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BUS: begin
                if (ack_c) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    fail    = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            slv_q   <= SLV_RAM;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                adr_q <= {core.core_addr[31:2], 2'b00};
                dat_q <= wdata_c;
                sel_q <= sel_c;
                off_q <= core.core_addr[1:0];
                we_q  <= core.core_we;
                slv_q <= (core.core_addr[19:16] == RSA_REGION) ? SLV_RSA : SLV_RAM;
                err_q <= 1'b0;
            end
            if (fail) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
            if (capture) begin
                err_q   <= 1'b0;
                rdata_q <= rdata_c;
            end
        end
    end

`ifdef DBUS_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    logic [TW-1:0] tmo_q;

    // tmo_q counts completed BUS cycles; the TIMEOUT-th unacked one aborts.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            tmo_q <= '0;
        end else if (state_q == ST_BUS) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign wb.wb_adr_o  = adr_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_sel_o  = sel_q;
    assign wb.wb_cyc_o  = (state_q == ST_BUS);
    assign wb.wb_we_o   = (state_q == ST_BUS) && we_q;
    assign wb.ram_stb_o = (state_q == ST_BUS) && (slv_q == SLV_RAM);
    assign wb.rsa_stb_o = (state_q == ST_BUS) && (slv_q == SLV_RSA);

    assign core.core_done  = (state_q == ST_RESP);
    assign core.core_err   = (state_q == ST_RESP) && err_q;
    assign core.core_rdata = rdata_q;
    assign core.core_stall = core.core_req && !core.core_done;

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// tb/tb_dbus_wb_bridge.sv - self-checking bench for dbus_wb_bridge
module tb_dbus_wb_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dbus_core_if core ();
    dbus_wb_if   wb ();

    dbus_wb_bridge dut (
        .clk  (clk),
        .rst  (rst),
        .core (core),
        .wb   (wb)
    );

    int total  = 0;
    int passed = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] sdat;
        logic        rsa;
        logic        spur;
        int          delay;
        int          lat;
        logic        bus;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input string nm, input logic we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] sdat, input logic rsa, input logic spur,
                                input int delay, input int lat, input logic bus,
                                input logic [3:0] sel, input logic [31:0] adr,
                                input logic [31:0] wdat, input logic err,
                                input logic [31:0] rdata);
        vec_t v;
        v.name = nm; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.sdat = sdat; v.rsa = rsa; v.spur = spur; v.delay = delay; v.lat = lat;
        v.bus = bus; v.sel = sel; v.adr = adr; v.wdat = wdat; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic clear_slaves();
        wb.ram_ack_i = 1'b0;
        wb.rsa_ack_i = 1'b0;
        wb.ram_dat_i = '0;
        wb.rsa_dat_i = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int   nbus;
        bit   got;
        exp_t e;
        sb.push_back('{v.name, v.err, v.rdata});
        @(posedge clk); #1;
        core.core_req   = 1'b1;
        core.core_we    = v.we;
        core.core_size  = v.size;
        core.core_addr  = v.addr;
        core.core_wdata = v.wdata;
        nbus = 0;
        got  = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (c == 0) chk({v.name, "_stall"}, 32'(core.core_stall), 32'd1);
            clear_slaves();
            if (wb.wb_cyc_o) begin
                if (!v.bus) begin
                    chk({v.name, "_nocyc"}, 32'(wb.wb_cyc_o), 32'd0);
                end else if (nbus == 0) begin
                    chk({v.name, "_adr"}, wb.wb_adr_o, v.adr);
                    chk({v.name, "_sel"}, 32'(wb.wb_sel_o), 32'(v.sel));
                    chk({v.name, "_dat"}, wb.wb_dat_o, v.wdat);
                    chk({v.name, "_we"}, 32'(wb.wb_we_o), 32'(v.we));
                    chk({v.name, "_ramstb"}, 32'(wb.ram_stb_o), 32'(!v.rsa));
                    chk({v.name, "_rsastb"}, 32'(wb.rsa_stb_o), 32'(v.rsa));
                end
                if (v.spur) begin
                    if (v.rsa) begin wb.ram_ack_i = 1'b1; wb.ram_dat_i = 32'hFFFF_FFFF; end
                    else       begin wb.rsa_ack_i = 1'b1; wb.rsa_dat_i = 32'hFFFF_FFFF; end
                end
                if (nbus == v.delay) begin
                    if (v.rsa) begin wb.rsa_ack_i = 1'b1; wb.rsa_dat_i = v.sdat; end
                    else       begin wb.ram_ack_i = 1'b1; wb.ram_dat_i = v.sdat; end
                end
                nbus++;
            end
            if (core.core_done) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    chk({v.name, "_sb_empty"}, 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_err"}, 32'(core.core_err), 32'(e.err));
                    chk({e.name, "_rdata"}, core.core_rdata, e.rdata);
                end
                chk({v.name, "_lat"}, 32'(c), 32'(v.lat));
                chk({v.name, "_stall_done"}, 32'(core.core_stall), 32'd0);
            end
        end
        if (!got) chk({v.name, "_done_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        core.core_req = 1'b0;
        clear_slaves();
    endtask

    initial begin
        bit any_done;
        bit seen;

        //       name      we   sz     addr          wdata         sdat          rsa  spur dly lat bus sel      adr           wdat          err  rdata
        vecs.push_back(mk("sw_ram",  1, 2'd2, 32'h0000_0010, 32'h1122_3344, 32'h0,         0, 0, 2, 4, 1, 4'b1111, 32'h0000_0010, 32'h1122_3344, 0, 32'h0));
        vecs.push_back(mk("sb_13",   1, 2'd0, 32'h0000_0013, 32'h0000_00AB, 32'h0,         0, 0, 0, 2, 1, 4'b1000, 32'h0000_0010, 32'hAB00_0000, 0, 32'h0));
        vecs.push_back(mk("lh_12",   0, 2'd1, 32'h0000_0012, 32'h0,         32'hBEEF_1234, 0, 0, 1, 3, 1, 4'b1100, 32'h0000_0010, 32'h0,         0, 32'h0000_BEEF));
        vecs.push_back(mk("lw_rsa",  0, 2'd2, 32'h0004_0008, 32'h0,         32'hCAFE_F00D, 1, 1, 1, 3, 1, 4'b1111, 32'h0004_0008, 32'h0,         0, 32'hCAFE_F00D));
        vecs.push_back(mk("lw_mis",  0, 2'd2, 32'h0000_0002, 32'h0,         32'h0,         0, 0, 0, 1, 0, 4'b0000, 32'h0,         32'h0,         1, 32'h0));
        vecs.push_back(mk("sh_mis",  1, 2'd1, 32'h0000_0001, 32'h1234,      32'h0,         0, 0, 0, 1, 0, 4'b0000, 32'h0,         32'h0,         1, 32'h0));
        vecs.push_back(mk("sz3",     0, 2'd3, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 0, 1, 0, 4'b0000, 32'h0,         32'h0,         1, 32'h0));
        vecs.push_back(mk("lb_rsa",  0, 2'd0, 32'h0004_0001, 32'h0000_0077, 32'h1122_3344, 1, 0, 3, 5, 1, 4'b0010, 32'h0004_0000, 32'h0000_7700, 0, 32'h0011_2233));
        vecs.push_back(mk("sh_r5",   1, 2'd1, 32'h0005_0002, 32'h0000_5678, 32'h0,         0, 0, 1, 3, 1, 4'b1100, 32'h0005_0000, 32'h5678_0000, 0, 32'h0));
        vecs.push_back(mk("lw_spur", 0, 2'd2, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 0, 1, 0, 2, 1, 4'b1111, 32'h0000_0004, 32'h0,         0, 32'hDEAD_BEEF));
        vecs.push_back(mk("sb_rsa",  1, 2'd0, 32'h0004_0002, 32'h0000_005A, 32'h0,         1, 0, 0, 2, 1, 4'b0100, 32'h0004_0000, 32'h005A_0000, 0, 32'h0));
        vecs.push_back(mk("lw_rmis", 0, 2'd2, 32'h0004_0003, 32'h0,         32'h0,         1, 0, 0, 1, 0, 4'b0000, 32'h0,         32'h0,         1, 32'h0));

        rst = 1'b1;
        core.core_req = 1'b0; core.core_we = 1'b0; core.core_size = 2'd0;
        core.core_addr = '0; core.core_wdata = '0;
        clear_slaves();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc",   32'(wb.wb_cyc_o),  32'd0);
        chk("rst_ramstb",32'(wb.ram_stb_o), 32'd0);
        chk("rst_rsastb",32'(wb.rsa_stb_o), 32'd0);
        chk("rst_we",    32'(wb.wb_we_o),   32'd0);
        chk("rst_sel",   32'(wb.wb_sel_o),  32'd0);
        chk("rst_adr",   wb.wb_adr_o,       32'd0);
        chk("rst_dat",   wb.wb_dat_o,       32'd0);
        chk("rst_done",  32'(core.core_done), 32'd0);
        chk("rst_err",   32'(core.core_err),  32'd0);
        chk("rst_rdata", core.core_rdata,     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Acks while idle must not start or finish anything.
        @(negedge clk);
        wb.ram_ack_i = 1'b1; wb.rsa_ack_i = 1'b1;
        any_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (core.core_done || wb.wb_cyc_o) any_done = 1'b1;
        end
        clear_slaves();
        chk("idle_ack_ignored", 32'(any_done), 32'd0);

        // Reset in the middle of a bus cycle.
        @(posedge clk); #1;
        core.core_req = 1'b1; core.core_we = 1'b0; core.core_size = 2'd2;
        core.core_addr = 32'h0000_0020;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (wb.wb_cyc_o) seen = 1'b1;
        end
        chk("rstbus_cyc_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstbus_cyc",    32'(wb.wb_cyc_o),  32'd0);
        chk("rstbus_ramstb", 32'(wb.ram_stb_o), 32'd0);
        chk("rstbus_done",   32'(core.core_done), 32'd0);
        @(posedge clk); #1;
        core.core_req = 1'b0;
        rst = 1'b0;
        any_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (core.core_done) any_done = 1'b1;
        end
        chk("rstbus_no_done", 32'(any_done), 32'd0);
        run_vec(mk("lw_after_rst", 0, 2'd2, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 0, 0, 1, 3, 1,
                   4'b1111, 32'h0000_0020, 32'h0, 0, 32'h0BAD_F00D));

`ifdef DBUS_TIMEOUT_EN
        run_vec(mk("lw_tmo", 0, 2'd2, 32'h0000_0030, 32'h0, 32'h1234_5678, 0, 0, 1000, 17, 1,
                   4'b1111, 32'h0000_0030, 32'h0, 1, 32'h0));
        run_vec(mk("lw_post_tmo", 0, 2'd2, 32'h0000_0034, 32'h0, 32'h5555_AAAA, 0, 0, 0, 2, 1,
                   4'b1111, 32'h0000_0034, 32'h0, 0, 32'h5555_AAAA));
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
